// File: rtl/imem_load_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_load_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FIRST,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_e;

  localparam int BYTES_PER_WORD         = 4;
  localparam int TIMEOUT_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/imem_load_ctrl_word_assembler.sv
// Big-endian byte-to-word assembler: the first byte received lands in the MSB.
// word_ready flags the capture that completes a word, and word carries that
// completed word in the same cycle. partial reports the byte index as it will
// be after this cycle's capture, so termination can see a byte that arrives
// together with the end of the load.
module word_assembler
  import imem_load_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        capture,
  input  logic [7:0]  byte_in,
  output logic        word_ready,
  output logic [31:0] word,
  output logic        partial
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q;

  assign word       = {word_q[23:0], byte_in};
  assign word_ready = capture && (idx_q == 2'(BYTES_PER_WORD - 1));
  assign idx_d      = clear ? 2'd0 : (capture ? idx_q + 2'd1 : idx_q);
  assign partial    = (idx_d != 2'd0);

  // Shift each captured byte in from the right and advance the index.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q  <= 2'd0;
      word_q <= 32'd0;
    end else begin
      idx_q <= idx_d;
      if (capture) word_q <= word;
    end
  end

endmodule

// File: rtl/imem_load_ctrl.sv
// Programming-mode controller: holds the CPU in reset while a UART byte stream
// is packed into 32-bit words and written to the instruction ROM from word 0.
// Optional feature macro: IMEM_LOAD_TIMEOUT_EN enables the idle timeout that
// ends a load after TIMEOUT_CYCLES cycles without a byte in RECV.
module imem_load_ctrl
  import imem_load_pkg::*;
#(
  parameter int ADDR_WIDTH     = 14,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_req,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_we,
  output logic [31:0]           rom_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  load_err
);

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic                  load_req_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic                  err_q, hold_q, done_q;
  logic [31:0]           wdata_q;

  logic        load_rise, capture, clear, full, timeout, ending;
  logic        word_ready, partial;
  logic [31:0] asm_word;

  assign load_rise = load_req && !load_req_q;
  assign capture   = rx_valid && (state_q == S_WAIT_FIRST || state_q == S_RECV ||
                                  state_q == S_WRITE);
  assign clear     = (state_q == S_IDLE) && load_rise;
  assign full      = (cnt_q == MAX_WORDS);
  assign ending    = (state_d == S_DONE) && (state_q != S_DONE);

  word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .capture    (capture),
    .byte_in    (rx_data),
    .word_ready (word_ready),
    .word       (asm_word),
    .partial    (partial)
  );

`ifdef IMEM_LOAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q;

  // Count consecutive byte-free cycles after the last byte; WRITE counts as idle.
  always_ff @(posedge clock) begin
    if (reset || rx_valid || !(state_q == S_RECV || state_q == S_WRITE)) to_q <= '0;
    else                                                                   to_q <= to_q + 1'b1;
  end

  assign timeout = (state_q == S_RECV) && !rx_valid && (to_q >= TW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  assign rom_addr   = (state_q == S_IDLE) ? fetch_addr : ptr_q;
  assign rom_we     = (state_q == S_WRITE) && !full;
  assign rom_wdata  = wdata_q;
  assign cpu_hold   = hold_q;
  assign load_done  = done_q;
  assign word_count = cnt_q;
  assign load_err   = err_q;

  // Next-state logic; a completed word always gets its WRITE before the load ends.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (load_rise) state_d = S_WAIT_FIRST;
      S_WAIT_FIRST: if (!load_req) state_d = S_DONE;
                    else if (rx_valid) state_d = S_RECV;
      S_RECV:       if (word_ready) state_d = S_WRITE;
                    else if (!load_req || timeout) state_d = S_DONE;
      S_WRITE:      state_d = S_RECV;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // State, write pointer, counters and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      load_req_q <= load_req;
      ptr_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      load_req_q <= load_req;
      hold_q     <= (state_d != S_IDLE);
      done_q     <= ending;
      if (word_ready) wdata_q <= asm_word;
      if (clear) begin
        ptr_q <= '0;
        cnt_q <= '0;
        err_q <= 1'b0;
      end else begin
        if (state_q == S_WRITE) begin
          if (full) err_q <= 1'b1;
          else begin
            ptr_q <= ptr_q + 1'b1;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        if (ending && partial) err_q <= 1'b1;
      end
    end
  end

endmodule
